// File: rtl/instr_pkg.sv
// Shared encodings, field widths and loader state type for the MIPS-style
// instruction encoder and its program loader.
package instr_pkg;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_ILL = 2'd3
  } fmt_e;

  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int JADR_W  = 26;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field-tuple to 32-bit instruction packer. Illegal tuples
// (reserved format or opcode bit 6 set) pack to a NOP and raise o_illegal.
module instr_pack
  import instr_pkg::*;
(
  input  logic [1:0]         i_fmt,
  input  logic [OPC_W:0]     i_opcode,
  input  logic [REG_W-1:0]   i_rs,
  input  logic [REG_W-1:0]   i_rt,
  input  logic [REG_W-1:0]   i_rd,
  input  logic [REG_W-1:0]   i_shamt,
  input  logic [FUNCT_W-1:0] i_funct,
  input  logic [IMM_W-1:0]   i_im,
  input  logic [JADR_W-1:0]  i_jump_adr,
  output logic [31:0]        o_word,
  output logic               o_illegal
);

  always_comb begin
    // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
    o_word    = INSTR_NOP;
    o_illegal = i_opcode[OPC_W];
    case (i_fmt)
      FMT_R:   o_word = {i_opcode[OPC_W-1:0], i_rs, i_rt, i_rd, i_shamt, i_funct};
      FMT_I:   o_word = {i_opcode[OPC_W-1:0], i_rs, i_rt, i_im};
      FMT_J:   o_word = {i_opcode[OPC_W-1:0], i_jump_adr};
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) o_word = INSTR_NOP;
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts field tuples over valid/ready, packs them and writes
// them to consecutive instruction-memory words for a programmed length.
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       im,
  input  logic [25:0]       jump_adr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int               CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic              r_err;

  logic              w_accept;
  logic              w_last;
  logic              w_illegal;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [31:0]       w_word;

  instr_pack u_pack (
    .i_fmt      (fmt),
    .i_opcode   (opcode),
    .i_rs       (rs),
    .i_rt       (rt),
    .i_rd       (rd),
    .i_shamt    (shamt),
    .i_funct    (funct),
    .i_im       (im),
    .i_jump_adr (jump_adr),
    .o_word     (w_word),
    .o_illegal  (w_illegal)
  );

  assign w_accept  = in_valid && (r_state == LOAD);
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_last    = (w_cnt_inc == r_len);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = (prog_len == '0) ? DONE : LOAD;
      LOAD:    if (w_accept && w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == LOAD);
    busy     = (r_state != IDLE);
    done     = (r_state == DONE);
  end

  // Start is honoured only in IDLE; the write port is registered one edge after accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_addr  <= BASE;
      r_we    <= 1'b0;
      r_waddr <= BASE;
      r_wdata <= INSTR_NOP;
      r_err   <= 1'b0;
    end else begin
      r_we <= w_accept;
      if ((r_state == IDLE) && start) begin
        r_cnt  <= '0;
        r_len  <= prog_len;
        r_addr <= BASE;
        r_err  <= 1'b0;
      end else if (w_accept) begin
        r_cnt   <= w_cnt_inc;
        r_addr  <= r_addr + ADDR_W'(1);
        r_waddr <= r_addr;
        r_wdata <= w_word;
        if (w_illegal) r_err <= 1'b1;
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_waddr;
  assign imem_wdata = r_wdata;
  assign err        = r_err;

endmodule
